dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory BRAM port between the core load/store path and a DMA
//  requester (bootloader / UART fill engine). Core has priority; a wait counter guarantees
//  DMA forward progress. One access is issued per cycle, and read data returns one cycle
//  later to the requester that issued it. Sits between the core byte-enable store logic and
//  the dmem BRAM.
// PARAMETERS
//  AWIDTH    14  word-address width of dmem
//  MAX_WAIT  4   consecutive denied DMA cycles before DMA is forced a grant (>=1)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  core_req    in   1       core requests an access this cycle
//  core_wea    in   4       core byte write enables; 4'b0000 = read
//  core_addr   in   AWIDTH  core word address
//  core_wdata  in   32      core write data, already lane-aligned
//  core_gnt    out  1       core access issued this cycle; core must stall while req&&!gnt
//  core_rvalid out  1       core read data valid (one cycle after granted read)
//  core_rdata  out  32      core read data
//  dma_req     in   1       DMA requests an access; held until granted
//  dma_wea     in   4       DMA byte write enables; 4'b0000 = read
//  dma_addr    in   AWIDTH  DMA word address
//  dma_wdata   in   32      DMA write data
//  dma_gnt     out  1       DMA access issued this cycle
//  dma_rvalid  out  1       DMA read data valid
//  dma_rdata   out  32      DMA read data
//  mem_en      out  1       BRAM port enable
//  mem_wea     out  4       BRAM byte write enables
//  mem_addr    out  AWIDTH  BRAM address
//  mem_din     out  32      BRAM write data
//  mem_dout    in   32      BRAM read data, registered, 1-cycle latency
// BEHAVIOUR
//  - Reset values: wait_cnt=0, rd_owner=NONE; all gnt/rvalid/mem_en/mem_wea = 0.
//  - Grant (combinational from req and registered wait_cnt):
//      force = dma_req && (wait_cnt == MAX_WAIT)
//      dma_gnt  = dma_req && (!core_req || force);  core_gnt = core_req && !dma_gnt
//  - Exactly one gnt high at most; mem_en = core_gnt|dma_gnt; mem_* mux from granted side.
//  - mem_wea = granted side's wea; with no grant, mem_wea=0 and mem_addr/mem_din hold the
//    core value (don't-care, not checked).
//  - wait_cnt: 0 on any cycle with dma_gnt or !dma_req; else +1, saturating at MAX_WAIT.
//  - rd_owner register <= CORE/DMA when the granted access has wea==0, else NONE.
//  - Next cycle: core_rvalid = (rd_owner==CORE), dma_rvalid = (rd_owner==DMA);
//    core_rdata = dma_rdata = mem_dout (valid only with the respective rvalid).
//  - Writes produce no rvalid. Partial-byte writes pass through unchanged.
//  - Read-after-write to the same address in consecutive cycles returns the new data
//    (BRAM is write-first).
//  - Core is denied at most one cycle per MAX_WAIT+1 cycles while DMA streams.
//  - Reset asserted mid-operation: pending rvalid dropped immediately (async), wait_cnt
//    cleared; no phantom rvalid after release.
//  - Requester deasserts req without grant: no state change other than wait_cnt rule.
// TESTING
//  1 Core only: read addr 0x010 (mem holds 0xDEADBEEF) -> core_gnt same cycle,
//    core_rvalid=1 and rdata=0xDEADBEEF next cycle, dma_rvalid=0.
//  2 DMA only: write wea=4'b0100 data=0x00AB0000 to 0x020, then read ->
//    byte 2 = 0xAB, other bytes unchanged, dma_rvalid 1 cycle after read grant.
//  3 Both held continuously, MAX_WAIT=4 -> 4 core grants, 1 DMA grant, repeating;
//    core_gnt low exactly on every 5th cycle.
//  4 Core read and DMA write back-to-back same cycle pair with DMA forced ->
//    rvalid routed only to the granting side; no cross-delivery.
//  5 Assert rst while core read issued -> core_rvalid 0 during and after reset,
//    wait_cnt restarts at 0 (next 4 denials before forced grant).
//  6 Random req/wea traffic vs reference model -> never both gnt, memory image matches.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory BRAM port between the core load/store path and
// a DMA requester (bootloader / UART fill engine). The core normally wins; a
// saturating wait counter forces a DMA grant after MAX_WAIT consecutive denied
// DMA cycles, so DMA always makes forward progress. One access is issued per
// cycle. Read data comes back from the BRAM one cycle later and is flagged valid
// only to the requester that issued the read.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   core_req_i/_wea_i/_addr_i/_wdata_i   core access request (wea==0 -> read)
//   core_gnt_o               core access issued this cycle (core stalls on req&&!gnt)
//   core_rvalid_o/_rdata_o   core read return, one cycle after a granted read
//   dma_req_i/_wea_i/_addr_i/_wdata_i    DMA access request, held until granted
//   dma_gnt_o                DMA access issued this cycle
//   dma_rvalid_o/_rdata_o    DMA read return, one cycle after a granted read
//   mem_en_o/_wea_o/_addr_o/_din_o       BRAM port (write-first, 1-cycle read)
//   mem_dout_i               BRAM registered read data
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int AWIDTH   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic [3:0]        core_wea_i,
  input  logic [AWIDTH-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  input  logic              dma_req_i,
  input  logic [3:0]        dma_wea_i,
  input  logic [AWIDTH-1:0] dma_addr_i,
  input  logic [31:0]       dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [31:0]       dma_rdata_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_wea_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  input  logic [31:0]       mem_dout_i
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  // Who issued the read whose data arrives on mem_dout_i this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic          force_dma;
  logic          dma_gnt;
  logic          core_gnt;

  // Grant, BRAM mux and next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    wait_cnt_d = wait_cnt_q;
    rd_owner_d = OWN_NONE;
    mem_wea_o  = 4'b0000;
    mem_addr_o = core_addr_i;
    mem_din_o  = core_wdata_i;

    force_dma = dma_req_i && (wait_cnt_q == WAIT_MAX);
    dma_gnt   = dma_req_i && (!core_req_i || force_dma);
    core_gnt  = core_req_i && !dma_gnt;

    if (dma_gnt) begin
      mem_wea_o  = dma_wea_i;
      mem_addr_o = dma_addr_i;
      mem_din_o  = dma_wdata_i;
      if (dma_wea_i == 4'b0000) rd_owner_d = OWN_DMA;
    end else if (core_gnt) begin
      mem_wea_o = core_wea_i;
      if (core_wea_i == 4'b0000) rd_owner_d = OWN_CORE;
    end

    // Counts consecutive cycles the DMA asked and was refused.
    if (dma_gnt || !dma_req_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  // NOTE: the reset is in the sensitivity list, so it clears the read owner
  // immediately and a pending rvalid drops without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign core_gnt_o    = core_gnt;
  assign dma_gnt_o     = dma_gnt;
  assign mem_en_o      = core_gnt | dma_gnt;
  assign core_rvalid_o = (rd_owner_q == OWN_CORE);
  assign dma_rvalid_o  = (rd_owner_q == OWN_DMA);
  assign core_rdata_o  = mem_dout_i;
  assign dma_rdata_o   = mem_dout_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Self-checking bench for dmem_port_arbiter: a table of single-cycle vectors
// from reset, hand-written multi-cycle sequences for priority/forced grant,
// read routing and reset, then held-until-granted random traffic against a
// reference model. A write-first BRAM with 1-cycle read latency is modelled here.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int AWIDTH   = 14;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              core_req = 1'b0, dma_req = 1'b0;
  logic [3:0]        core_wea = '0, dma_wea = '0;
  logic [AWIDTH-1:0] core_addr = '0, dma_addr = '0;
  logic [31:0]       core_wdata = '0, dma_wdata = '0;
  logic              core_gnt, core_rvalid, dma_gnt, dma_rvalid;
  logic [31:0]       core_rdata, dma_rdata;
  logic              mem_en;
  logic [3:0]        mem_wea;
  logic [AWIDTH-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AWIDTH(AWIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req), .core_wea_i(core_wea), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .core_rdata_o(core_rdata),
    .dma_req_i(dma_req), .dma_wea_i(dma_wea), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid),
    .dma_rdata_o(dma_rdata),
    .mem_en_o(mem_en), .mem_wea_o(mem_wea), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] wea);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (wea[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  // Write-first BRAM model with a backdoor preload port.
  logic [31:0]       mem_arr [0:(1<<AWIDTH)-1];
  logic              pl_en = 1'b0;
  logic [AWIDTH-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      mem_arr[mem_addr] <= merge(mem_arr[mem_addr], mem_din, mem_wea);
      mem_dout          <= merge(mem_arr[mem_addr], mem_din, mem_wea);
    end else if (pl_en) begin
      mem_arr[pl_addr] <= pl_data;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // own: 0 none, 1 core, 2 dma
  task automatic check_rv(input string nm, input int own, input logic [31:0] d);
    check({nm, "_rvalid"}, {core_rvalid, dma_rvalid},
          (own == 1) ? 2'b10 : (own == 2) ? 2'b01 : 2'b00);
    if (own == 1) check({nm, "_core_rdata"}, core_rdata, d);
    else if (own == 2) check({nm, "_dma_rdata"}, dma_rdata, d);
  endtask

  task automatic preload(input logic [AWIDTH-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic cr, input logic [3:0] cw, input logic [AWIDTH-1:0] ca,
                       input logic [31:0] cd, input logic dr, input logic [3:0] dw,
                       input logic [AWIDTH-1:0] da, input logic [31:0] dd);
    core_req = cr; core_wea = cw; core_addr = ca; core_wdata = cd;
    dma_req  = dr; dma_wea  = dw; dma_addr  = da; dma_wdata  = dd;
  endtask

  task automatic idle();
    @(negedge clk);
    core_req = 1'b0; dma_req = 1'b0;
  endtask

  typedef struct {
    logic cr; logic [3:0] cw; logic dr; logic [3:0] dw;
    logic cg; logic dg; logic [3:0] wea; logic crv; logic drv;
  } vec_t;

  vec_t vecs [13];
  logic [31:0] ref_mem [16];

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int own;
    int m_wait;
    logic pending;
    logic f, edg, ecg;
    logic [31:0] exp_d;

    //          cr  cw    dr  dw     cg  dg  wea   crv drv
    vecs[0]  = '{0, 4'h0, 0, 4'h0,   0,  0,  4'h0, 0,  0};  // idle after reset
    vecs[1]  = '{1, 4'h0, 0, 4'h0,   1,  0,  4'h0, 0,  0};  // core read
    vecs[2]  = '{0, 4'h0, 1, 4'hF,   0,  1,  4'hF, 1,  0};  // dma write, core rvalid
    vecs[3]  = '{1, 4'h3, 1, 4'h0,   1,  0,  4'h3, 0,  0};  // core wins, wait=1
    vecs[4]  = '{1, 4'h0, 1, 4'h0,   1,  0,  4'h0, 0,  0};  // wait=2
    vecs[5]  = '{1, 4'h0, 1, 4'h0,   1,  0,  4'h0, 1,  0};  // wait=3
    vecs[6]  = '{1, 4'h0, 1, 4'h0,   1,  0,  4'h0, 1,  0};  // wait=4
    vecs[7]  = '{1, 4'h0, 1, 4'h0,   0,  1,  4'h0, 1,  0};  // forced dma read
    vecs[8]  = '{1, 4'h0, 1, 4'h0,   1,  0,  4'h0, 0,  1};  // dma rvalid
    vecs[9]  = '{0, 4'h0, 0, 4'h0,   0,  0,  4'h0, 1,  0};  // dma drops, wait clears
    vecs[10] = '{1, 4'h0, 1, 4'h2,   1,  0,  4'h0, 0,  0};  // wait=1 only
    vecs[11] = '{0, 4'h0, 1, 4'h2,   0,  1,  4'h2, 1,  0};  // partial dma write
    vecs[12] = '{0, 4'h0, 0, 4'h0,   0,  0,  4'h0, 0,  0};  // write gives no rvalid

    // Preload under reset; the DUT is idle so the backdoor port is free.
    preload(14'h010, 32'hDEADBEEF);
    preload(14'h020, 32'h11223344);
    preload(14'h040, 32'h40404040);
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = 32'h3000_0000 + 32'h0101_0101 * a;
      preload(AWIDTH'(14'h300 + a), ref_mem[a]);
    end
    @(negedge clk);
    #1;
    check("reset_outputs", {core_gnt, dma_gnt, mem_en, mem_wea, core_rvalid, dma_rvalid}, '0);
    rst = 1'b0;

    // ---- table-driven single-cycle vectors ----
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].cr, vecs[i].cw, AWIDTH'(14'h100 + i), 32'hC000_0000 | i,
            vecs[i].dr, vecs[i].dw, AWIDTH'(14'h200 + i), 32'hD000_0000 | i);
      #1;
      check($sformatf("vec%0d", i),
            {core_gnt, dma_gnt, mem_en, mem_wea, core_rvalid, dma_rvalid},
            {vecs[i].cg, vecs[i].dg, vecs[i].cg | vecs[i].dg, vecs[i].wea,
             vecs[i].crv, vecs[i].drv});
      if (vecs[i].cg | vecs[i].dg)
        check($sformatf("vec%0d_mux", i), {mem_addr, mem_din},
              vecs[i].dg ? {dma_addr, dma_wdata} : {core_addr, core_wdata});
    end

    // ---- core-only read ----
    @(negedge clk);
    drive(1, 4'h0, 14'h010, 0, 0, 4'h0, 0, 0);
    #1 check("t1_gnt", {core_gnt, dma_gnt}, 2'b10);
    idle();
    #1 check_rv("t1", 1, 32'hDEADBEEF);

    // ---- DMA-only partial write then read ----
    @(negedge clk);
    drive(0, 4'h0, 0, 0, 1, 4'b0100, 14'h020, 32'h00AB_0000);
    #1 check("t2_wr_gnt", {core_gnt, dma_gnt, mem_wea}, {2'b01, 4'b0100});
    @(negedge clk);
    dma_wea = 4'b0000;
    #1 check("t2_rd_gnt", dma_gnt, 1'b1);
    check_rv("t2_after_write", 0, 0);
    idle();
    #1 check_rv("t2", 2, 32'h11AB_3344);

    // ---- both held: core denied exactly every 5th cycle ----
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1, 4'h0, 14'h100, 0, 1, 4'h0, 14'h200, 0);
      #1 check($sformatf("t3_gnt%0d", k), {core_gnt, dma_gnt},
               (k % 5 == 4) ? 2'b01 : 2'b10);
    end
    idle();

    // ---- routing: core reads against forced DMA write, then forced DMA read ----
    own = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1, 4'h0, 14'h040, 0, 1, (k < 5) ? 4'hF : 4'h0, 14'h050, 32'h5555_AAAA);
      #1;
      check($sformatf("t4_gnt%0d", k), {core_gnt, dma_gnt}, (k % 5 == 4) ? 2'b01 : 2'b10);
      check_rv($sformatf("t4_%0d", k), own, (own == 2) ? 32'h5555_AAAA : 32'h4040_4040);
      own = (k % 5 != 4) ? 1 : (k < 5) ? 0 : 2;
    end
    idle();
    #1 check_rv("t4_last", own, 32'h5555_AAAA);

    // ---- reset during an outstanding core read ----
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1, 4'h0, 14'h040, 0, 1, 4'h0, 14'h050, 0);
    end
    @(posedge clk);
    #1 check("t5_before_rst", core_rvalid, 1'b1);
    rst = 1'b1;
    #1 check("t5_async_drop", {core_rvalid, dma_rvalid}, 2'b00);
    @(negedge clk);
    #1 check("t5_in_rst", {core_rvalid, dma_rvalid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t5_release", {core_rvalid, dma_rvalid}, 2'b00);
    check("t5_gnt0", {core_gnt, dma_gnt}, 2'b10);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      #1 check($sformatf("t5_gnt%0d", k), {core_gnt, dma_gnt}, (k == 4) ? 2'b01 : 2'b10);
    end
    idle();

    // ---- random traffic against a reference model ----
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    own = 0; exp_d = '0; m_wait = 0; pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      core_req   = 1'($urandom_range(0, 1));
      core_wea   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      core_addr  = AWIDTH'(14'h300 + $urandom_range(0, 15));
      core_wdata = $urandom;
      if (!pending) begin
        dma_req   = ($urandom_range(0, 2) == 0);
        dma_wea   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        dma_addr  = AWIDTH'(14'h300 + $urandom_range(0, 15));
        dma_wdata = $urandom;
        pending   = dma_req;
      end
      #1;
      check_rv($sformatf("t6_c%0d", c), own, exp_d);
      f   = dma_req && (m_wait == MAX_WAIT);
      edg = dma_req && (!core_req || f);
      ecg = core_req && !edg;
      check($sformatf("t6_gnt_c%0d", c), {core_gnt, dma_gnt, mem_en}, {ecg, edg, ecg | edg});
      own = 0;
      if (edg) begin
        ref_mem[dma_addr[3:0]] = merge(ref_mem[dma_addr[3:0]], dma_wdata, dma_wea);
        exp_d = ref_mem[dma_addr[3:0]];
        if (dma_wea == 4'h0) own = 2;
        pending = 1'b0;
      end else if (ecg) begin
        ref_mem[core_addr[3:0]] = merge(ref_mem[core_addr[3:0]], core_wdata, core_wea);
        exp_d = ref_mem[core_addr[3:0]];
        if (core_wea == 4'h0) own = 1;
      end
      if (edg || !dma_req) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
    end
    idle();
    #1 check_rv("t6_tail", own, exp_d);
    @(negedge clk);
    for (int a = 0; a < 16; a++)
      check($sformatf("t6_image%0d", a), mem_arr[14'h300 + a], ref_mem[a]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
